pool_max_1d_stream: RTL and testbench

POOL_MAX_1D_STREAM -- requirements
Module: pool_max_1d_stream

---
 rtl/pool_max_1d_stream_pkg.sv | 19 +
 rtl/pool_max_1d_stream_if.sv | 21 ++
 rtl/pool_max_1d_stream_window_acc.sv | 62 ++++++
 rtl/pool_max_1d_stream.sv | 97 +++++++++
 tb/tb_pool_max_1d_stream.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pool_max_1d_stream_pkg.sv
// Shared defaults, widths and types for the 1-D max/average pooling stream block.
// Optional build macro: POOL_AVG_EN (average pooling instead of max pooling).
package pool_pkg;

   localparam int unsigned POOL_T = 8;
   localparam int unsigned POOL_P = 4;
   localparam int unsigned POOL_L = 97;
   localparam int unsigned WIN_W  = $clog2(POOL_P);
   localparam int unsigned FRM_W  = $clog2(POOL_L);

   typedef logic signed [POOL_T-1:0]       sample_t;
   typedef logic signed [POOL_T+WIN_W-1:0] acc_t;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } pool_state_e;

endpackage

// File: rtl/pool_max_1d_stream_if.sv
// Upstream sample stream and downstream result stream of the pooling block.
interface pool_max_1d_stream_if #(
   parameter int unsigned T = pool_pkg::POOL_T
);
   logic                s_valid_y;
   logic                s_ready_y;
   logic signed [T-1:0] s_data_in_y;
   logic                m_valid_z;
   logic                m_ready_z;
   logic signed [T-1:0] m_data_out_z;

   modport master (
      output s_valid_y, s_data_in_y, m_ready_z,
      input  s_ready_y, m_valid_z, m_data_out_z
   );

   modport slave (
      input  s_valid_y, s_data_in_y, m_ready_z,
      output s_ready_y, m_valid_z, m_data_out_z
   );
endinterface

// File: rtl/pool_max_1d_stream_window_acc.sv
// Window register and reduction datapath: running signed max, or running sum when POOL_AVG_EN.
// dout is the window value including the current din, so the completing sample is reflected.
module pool_window_acc
   import pool_pkg::*;
#(
   parameter int unsigned T = POOL_T,
   parameter int unsigned P = POOL_P
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_first,
   input  logic                en,
   input  logic signed [T-1:0] din,
   output logic signed [T-1:0] dout
);

`ifdef POOL_AVG_EN
   localparam int unsigned WW = $clog2(P);
   localparam int unsigned AW = T + WW;
`else
   localparam int unsigned AW = T;
`endif

   logic signed [AW-1:0] acc_q;
   logic signed [AW-1:0] acc_d;
   logic signed [AW-1:0] din_x;

   assign din_x = AW'(din);

   // Equal values keep the register (strict greater-than).
   always_comb begin
      acc_d = acc_q;
      if (en) begin
         if (load_first) begin
            acc_d = din_x;
         end else begin
`ifdef POOL_AVG_EN
            acc_d = acc_q + din_x;
`else
            if (din_x > acc_q) begin
               acc_d = din_x;
            end
`endif
         end
      end
   end

`ifdef POOL_AVG_EN
   assign dout = T'(acc_d >>> WW);
`else
   assign dout = acc_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/pool_max_1d_stream.sv
// 1-D pooling over a framed sample stream: one result per P samples, trailing partial window dropped.
// Build macro POOL_AVG_EN selects average pooling; default is signed max pooling.
module pool_max_1d_stream
   import pool_pkg::*;
#(
   parameter int unsigned T = POOL_T,
   parameter int unsigned P = POOL_P,
   parameter int unsigned L = POOL_L
) (
   input  logic                 clk,
   input  logic                 reset,
   pool_max_1d_stream_if.slave  bus
);

   localparam int unsigned WW = $clog2(P);
   localparam int unsigned FW = $clog2(L);

   pool_state_e         state_q, state_d;
   logic [WW-1:0]       win_cnt_q, win_cnt_d;
   logic [FW-1:0]       frm_cnt_q, frm_cnt_d;
   logic signed [T-1:0] data_q, data_d;
   logic signed [T-1:0] win_val;

   logic accept;
   logic transfer;
   logic win_last;
   logic frm_last;
   logic load_first;
   logic complete;

   assign bus.m_valid_z    = (state_q == HOLD);
   assign bus.m_data_out_z = data_q;
   assign bus.s_ready_y    = ~bus.m_valid_z | bus.m_ready_z;

   assign accept     = bus.s_valid_y & bus.s_ready_y;
   assign transfer   = bus.m_valid_z & bus.m_ready_z;
   assign win_last   = (win_cnt_q == WW'(P - 1));
   assign frm_last   = (frm_cnt_q == FW'(L - 1));
   assign load_first = (win_cnt_q == '0);
   assign complete   = accept & win_last;

   pool_window_acc #(
      .T (T),
      .P (P)
   ) u_acc (
      .clk        (clk),
      .rst_n      (reset),
      .load_first (load_first),
      .en         (accept),
      .din        (bus.s_data_in_y),
      .dout       (win_val)
   );

   // Frame end clears both counters so a trailing partial window is simply never completed.
   always_comb begin
      win_cnt_d = win_cnt_q;
      frm_cnt_d = frm_cnt_q;
      state_d   = state_q;
      data_d    = data_q;

      if (accept) begin
         win_cnt_d = (win_last | frm_last) ? '0 : win_cnt_q + WW'(1);
         frm_cnt_d = frm_last ? '0 : frm_cnt_q + FW'(1);
      end

      case (state_q)
         COLLECT: begin
            if (complete) begin
               state_d = HOLD;
               data_d  = win_val;
            end
         end
         HOLD: begin
            if (complete) begin
               data_d = win_val;
            end else if (transfer) begin
               state_d = COLLECT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= COLLECT;
         win_cnt_q <= '0;
         frm_cnt_q <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         win_cnt_q <= win_cnt_d;
         frm_cnt_q <= frm_cnt_d;
         data_q    <= data_d;
      end
   end

endmodule

// File: tb/tb_pool_max_1d_stream.sv
// Self-checking bench for pool_max_1d_stream: queue-based window model plus directed literal pins.
module tb_pool_max_1d_stream;

   localparam int unsigned T = 8;
   localparam int unsigned P = 4;
   localparam int unsigned L = 97;
`ifdef POOL_AVG_EN
   localparam int OFF = 1;
`else
   localparam int OFF = 3;
`endif

   logic clk;
   logic rst_n;
   bit   acc;

   int errors;
   int checks;

   int win[$];
   int exp_q[$];
   int got[$];
   int kpos;

   pool_max_1d_stream_if #(.T(T)) bus ();

   pool_max_1d_stream #(
      .T (T),
      .P (P),
      .L (L)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   function automatic int window_result();
      int r;
`ifdef POOL_AVG_EN
      r = 0;
      foreach (win[i]) r += win[i];
      r = r >>> $clog2(P);
`else
      r = win[0];
      foreach (win[i]) if (win[i] > r) r = win[i];
`endif
      return r;
   endfunction

   task automatic model_push(input int d);
      win.push_back(d);
      if (win.size() == P) begin
         exp_q.push_back(window_result());
         win.delete();
      end
      kpos++;
      if (kpos == L) begin
         kpos = 0;
         win.delete();
      end
   endtask

   task automatic model_clear();
      win.delete();
      exp_q.delete();
      kpos = 0;
   endtask

   // One cycle: drive at negedge, compare outputs against the model, then advance the model.
   task automatic step(input bit v, input logic signed [T-1:0] d, input bit r, output bit accepted);
      bit exp_valid;
      @(negedge clk);
      bus.s_valid_y   = v;
      bus.s_data_in_y = d;
      bus.m_ready_z   = r;
      #1;
      exp_valid = (exp_q.size() != 0);
      chk("m_valid", int'(bus.m_valid_z), int'(exp_valid));
      chk("s_ready", int'(bus.s_ready_y), int'(!exp_valid || r));
      if (exp_valid) begin
         chk("m_data", int'(bus.m_data_out_z), exp_q[0]);
         if (r) begin
            got.push_back(int'(bus.m_data_out_z));
            void'(exp_q.pop_front());
         end
      end
      accepted = v && (!exp_valid || r);
      if (accepted) model_push(int'(d));
   endtask

   task automatic send(input int d, input bit r);
      bit a;
      int n;
      a = 1'b0;
      n = 0;
      while (!a && n < 64) begin
         step(1'b1, T'(d), r, a);
         n++;
      end
      if (!a) chk("send_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.s_valid_y = 1'b0;
      bus.m_ready_z = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_m_valid", int'(bus.m_valid_z), 0);
      chk("rst_m_data", int'(bus.m_data_out_z), 0);
      chk("rst_s_ready", int'(bus.s_ready_y), 1);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int pin_in[12];
      int pin_out[3];
      int npin;
      errors = 0;
      checks = 0;
      kpos   = 0;
      rst_n  = 1'b0;
      bus.s_valid_y   = 1'b0;
      bus.s_data_in_y = '0;
      bus.m_ready_z   = 1'b0;
      do_reset();

      // First window, then backpressure while the result is held.
      got.delete();
      for (int i = 0; i < 4; i++) send(i, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, T'(4), 1'b0, acc);
         chk("bp_valid", int'(bus.m_valid_z), 1);
         chk("bp_hold", int'(bus.m_data_out_z), OFF);
         chk("bp_ready", int'(bus.s_ready_y), 0);
      end
      for (int i = 4; i < 97; i++) send(i, 1'b1);
      chk("frame0_count", got.size(), 24);
      for (int i = 0; i < got.size(); i++) chk("frame0_result", got[i], 4 * i + OFF);

      // Back-to-back second frame must restart window alignment.
      got.delete();
      for (int i = 100; i < 197; i++) send(i, 1'b1);
      chk("frame1_first", got[0], 100 + OFF);

      // Signed edge windows.
      do_reset();
      got.delete();
`ifdef POOL_AVG_EN
      pin_in  = '{4, 8, 12, 16, -3, -3, -3, -2, 127, 127, 127, 127};
      pin_out = '{10, -3, 127};
      npin = 3;
`else
      pin_in  = '{-5, -2, -128, -1, -128, -128, -128, -128, 0, 0, 0, 0};
      pin_out = '{-1, -128, 0};
      npin = 2;
`endif
      for (int i = 0; i < 4 * npin; i++) send(pin_in[i], 1'b1);
      step(1'b0, '0, 1'b1, acc);
      chk("pin_count", got.size(), npin);
      for (int i = 0; i < npin; i++) chk("pin_value", got[i], pin_out[i]);

      // Reset in the middle of a window discards partial state.
      do_reset();
      got.delete();
      for (int i = 1; i < 5; i++) send(i, 1'b1);
      send(7, 1'b1);
      send(8, 1'b0);
      do_reset();
      got.delete();
      send(1, 1'b1);
      send(9, 1'b1);
      send(2, 1'b1);
      send(3, 1'b1);
      step(1'b0, '0, 1'b1, acc);
      chk("post_reset_count", got.size(), 1);
`ifdef POOL_AVG_EN
      chk("post_reset_result", got[0], 3);
`else
      chk("post_reset_result", got[0], 9);
`endif

      // Random traffic with random valid gaps and random downstream stalls.
      for (int c = 0; c < 2000; c++) begin
         step($urandom_range(0, 3) != 0, T'($urandom_range(0, 255)), $urandom_range(0, 2) != 0, acc);
      end
      repeat (4) step(1'b0, '0, 1'b1, acc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
